// File: rtl/sdram_req_frontend.sv
// rtl/sdram_req_frontend.sv - debounced push-button front-end driving sdram_controller req/ack
module sdram_req_frontend #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int ADDR_W          = 22,
  parameter int DATA_W          = 128
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              iwrite_key_n,
  input  logic              iread_key_n,
  input  logic [ADDR_W-1:0] iaddress,
  input  logic [DATA_W-1:0] iwrite_data,
  output logic              owrite_req,
  output logic [ADDR_W-1:0] owrite_address,
  output logic [DATA_W-1:0] owrite_data,
  input  logic              iwrite_ack,
  output logic              oread_req,
  output logic [ADDR_W-1:0] oread_address,
  input  logic [DATA_W-1:0] iread_data,
  input  logic              iread_ack,
  output logic [DATA_W-1:0] odisplay_data,
  output logic              obusy,
  output logic              otimeout,
  output logic [2:0]        ostate
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WR_FIN = 3'd2,
    RD     = 3'd3,
    RD_FIN = 3'd4,
    TOUT   = 3'd5
  } state_t;

  // bit 0 = write key, bit 1 = read key
  logic [1:0]     key_meta, key_sync, key_db, key_db_q, press;
  logic [DBW-1:0] db_cnt [2];
  logic [TW-1:0]  wait_cnt;
  state_t         state, next;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      key_meta  <= 2'b11;
      key_sync  <= 2'b11;
      key_db    <= 2'b11;
      key_db_q  <= 2'b11;
      press     <= 2'b00;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      key_meta <= {iread_key_n, iwrite_key_n};
      key_sync <= key_meta;
      key_db_q <= key_db;
      press    <= key_db_q & ~key_db;
      for (int i = 0; i < 2; i++) begin
        if (key_sync[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          key_db[i] <= key_sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Write wins a same-cycle tie; pulses outside IDLE are simply not looked at.
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = press[0] ? WR : (press[1] ? RD : IDLE);
      WR:      next = iwrite_ack ? WR_FIN : ((wait_cnt == TO_LAST) ? TOUT : WR);
      RD:      next = iread_ack ? RD_FIN : ((wait_cnt == TO_LAST) ? TOUT : RD);
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      owrite_req     <= 1'b0;
      oread_req      <= 1'b0;
      owrite_address <= '0;
      owrite_data    <= '0;
      oread_address  <= '0;
      odisplay_data  <= '0;
      obusy          <= 1'b0;
      otimeout       <= 1'b0;
    end else begin
      state      <= next;
      owrite_req <= (next == WR);
      oread_req  <= (next == RD);
      obusy      <= (next != IDLE);
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (wait_cnt != TO_LAST) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == IDLE && next == WR) begin
        owrite_address <= iaddress;
        owrite_data    <= iwrite_data;
        otimeout       <= 1'b0;
      end
      if (state == IDLE && next == RD) begin
        oread_address <= iaddress;
        otimeout      <= 1'b0;
      end
      if (next == TOUT) otimeout <= 1'b1;
      if (state == RD && iread_ack) odisplay_data <= iread_data;
    end
  end

  assign ostate = state;

endmodule

// File: tb/tb_sdram_req_frontend.sv
// tb/tb_sdram_req_frontend.sv - directed self-checking bench for sdram_req_frontend
module tb_sdram_req_frontend;

  logic         iclk = 1'b0;
  logic         ireset_n = 1'b0;
  logic         iwrite_key_n = 1'b1;
  logic         iread_key_n = 1'b1;
  logic [21:0]  iaddress = '0;
  logic [127:0] iwrite_data = '0;
  logic         owrite_req;
  logic [21:0]  owrite_address;
  logic [127:0] owrite_data;
  logic         iwrite_ack = 1'b0;
  logic         oread_req;
  logic [21:0]  oread_address;
  logic [127:0] iread_data = '0;
  logic         iread_ack = 1'b0;
  logic [127:0] odisplay_data;
  logic         obusy;
  logic         otimeout;
  logic [2:0]   ostate;

  int total = 0;
  int bad = 0;
  int wr_rise = 0, rd_rise = 0, wr_hi = 0, rd_hi = 0;
  logic wr_prev = 1'b0, rd_prev = 1'b0;

  sdram_req_frontend #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (16),
    .ADDR_W         (22),
    .DATA_W         (128)
  ) dut (
    .iclk          (iclk),
    .ireset_n      (ireset_n),
    .iwrite_key_n  (iwrite_key_n),
    .iread_key_n   (iread_key_n),
    .iaddress      (iaddress),
    .iwrite_data   (iwrite_data),
    .owrite_req    (owrite_req),
    .owrite_address(owrite_address),
    .owrite_data   (owrite_data),
    .iwrite_ack    (iwrite_ack),
    .oread_req     (oread_req),
    .oread_address (oread_address),
    .iread_data    (iread_data),
    .iread_ack     (iread_ack),
    .odisplay_data (odisplay_data),
    .obusy         (obusy),
    .otimeout      (otimeout),
    .ostate        (ostate)
  );

  always #5 iclk = ~iclk;

  // Request monitor: cycles high and rising edges, sampled mid-cycle.
  always @(negedge iclk) begin
    if (owrite_req) wr_hi++;
    if (oread_req) rd_hi++;
    if (owrite_req && !wr_prev) wr_rise++;
    if (oread_req && !rd_prev) rd_rise++;
    wr_prev = owrite_req;
    rd_prev = oread_req;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic wait_req(input bit rd, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if ((rd ? oread_req : owrite_req) === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int w0, wh0, r0, rh0;
    bit nonidle;
    bit found;

    tick(3);
    check("rst_wr_req", owrite_req, 0);
    check("rst_rd_req", oread_req, 0);
    check("rst_busy", obusy, 0);
    check("rst_timeout", otimeout, 0);
    check("rst_state", ostate, 0);
    check("rst_display", odisplay_data, 0);
    check("rst_wr_addr", owrite_address, 0);
    check("rst_wr_data", owrite_data, 0);
    ireset_n = 1'b1;
    tick(3);

    // write: key held 20 cycles, ack 3 cycles after request rises
    iaddress = 22'd2;
    iwrite_data = 128'hA5;
    w0 = wr_rise; wh0 = wr_hi;
    iwrite_key_n = 1'b0;
    wait_req(1'b0, cyc);
    check("wr_latency", cyc, 8);
    check("wr_state_wr", ostate, 1);
    check("wr_addr", owrite_address, 2);
    check("wr_data", owrite_data, 128'hA5);
    check("wr_busy", obusy, 1);
    tick(3);
    check("wr_req_held", owrite_req, 1);
    iwrite_ack = 1'b1;
    tick(1);
    check("wr_req_drop", owrite_req, 0);
    check("wr_state_fin", ostate, 2);
    iwrite_ack = 1'b0;
    tick(1);
    check("wr_state_idle", ostate, 0);
    tick(7);
    iwrite_key_n = 1'b1;
    tick(12);
    check("wr_single", wr_rise - w0, 1);
    check("wr_high_cycles", wr_hi - wh0, 4);

    // bounce: toggles every 2 cycles never settle long enough
    w0 = wr_rise;
    nonidle = 1'b0;
    for (int i = 0; i < 8; i++) begin
      iwrite_key_n = ~iwrite_key_n;
      tick(1); nonidle |= (ostate != 3'd0);
      tick(1); nonidle |= (ostate != 3'd0);
    end
    iwrite_key_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1); nonidle |= (ostate != 3'd0);
    end
    check("bounce_no_req", wr_rise - w0, 0);
    check("bounce_idle", nonidle, 0);

    // read returning 0x3C, then a write of 0xFF with ack already high
    iaddress = 22'd1;
    iread_key_n = 1'b0;
    wait_req(1'b1, cyc);
    check("rd_seen", cyc, 8);
    check("rd_addr", oread_address, 1);
    check("rd_disp_before", odisplay_data, 0);
    iread_data = 128'h3C;
    iread_ack = 1'b1;
    tick(1);
    check("rd_disp", odisplay_data, 128'h3C);
    check("rd_state_fin", ostate, 4);
    check("rd_req_drop", oread_req, 0);
    iread_ack = 1'b0;
    iread_data = 128'h99;
    iread_key_n = 1'b1;
    tick(12);
    iwrite_data = 128'hFF;
    iwrite_ack = 1'b1;
    wh0 = wr_hi;
    iwrite_key_n = 1'b0;
    wait_req(1'b0, cyc);
    check("wr2_seen", cyc, 8);
    tick(1);
    check("wr2_state_fin", ostate, 2);
    iwrite_ack = 1'b0;
    iwrite_key_n = 1'b1;
    tick(12);
    check("wr2_one_cycle", wr_hi - wh0, 1);
    check("wr2_data", owrite_data, 128'hFF);
    check("disp_hold", odisplay_data, 128'h3C);

    // timeout then recovery with a read
    wh0 = wr_hi;
    iwrite_key_n = 1'b0;
    wait_req(1'b0, cyc);
    check("to_seen", cyc, 8);
    iwrite_key_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (ostate == 3'd5) found = 1'b1;
    end
    check("to_reached", found, 1);
    check("to_flag", otimeout, 1);
    check("to_high_cycles", wr_hi - wh0, 16);
    check("to_disp_kept", odisplay_data, 128'h3C);
    tick(1);
    check("to_idle", ostate, 0);
    check("to_sticky", otimeout, 1);
    tick(10);
    iread_key_n = 1'b0;
    wait_req(1'b1, cyc);
    check("rec_seen", cyc, 8);
    check("rec_to_clear", otimeout, 0);
    iread_data = 128'h5A;
    iread_ack = 1'b1;
    tick(1);
    check("rec_disp", odisplay_data, 128'h5A);
    iread_ack = 1'b0;
    iread_key_n = 1'b1;
    tick(1);
    check("rec_idle", ostate, 0);
    tick(12);

    // contention, then a read press that lands during WR
    r0 = rd_rise; rh0 = rd_hi;
    iwrite_key_n = 1'b0;
    iread_key_n = 1'b0;
    wait_req(1'b0, cyc);
    check("cont_seen", cyc, 8);
    check("cont_no_rd", oread_req, 0);
    iwrite_key_n = 1'b1;
    iread_key_n = 1'b1;
    tick(5);
    iread_key_n = 1'b0;
    tick(8);
    check("cont_still_wr", ostate, 1);
    iwrite_ack = 1'b1;
    tick(1);
    check("cont_wr_fin", ostate, 2);
    iwrite_ack = 1'b0;
    tick(15);
    check("cont_no_read", rd_rise - r0, 0);
    check("cont_no_rd_hi", rd_hi - rh0, 0);
    check("cont_idle", ostate, 0);
    iread_key_n = 1'b1;
    tick(12);

    // read 0x3C, then reset in the middle of the following read
    iread_key_n = 1'b0;
    wait_req(1'b1, cyc);
    iread_data = 128'h3C;
    iread_ack = 1'b1;
    tick(1);
    iread_ack = 1'b0;
    iread_key_n = 1'b1;
    tick(12);
    check("pre_rst_disp", odisplay_data, 128'h3C);
    iread_key_n = 1'b0;
    wait_req(1'b1, cyc);
    check("rst_rd_seen", cyc, 8);
    iread_key_n = 1'b1;
    #2;
    ireset_n = 1'b0;
    #1;
    check("mid_rst_rd_req", oread_req, 0);
    check("mid_rst_disp", odisplay_data, 0);
    check("mid_rst_state", ostate, 0);
    check("mid_rst_busy", obusy, 0);
    tick(2);
    ireset_n = 1'b1;
    tick(3);
    iaddress = 22'd7;
    iwrite_data = 128'h1234;
    iwrite_key_n = 1'b0;
    wait_req(1'b0, cyc);
    check("post_rst_seen", cyc, 8);
    check("post_rst_addr", owrite_address, 7);
    check("post_rst_data", owrite_data, 128'h1234);
    iwrite_ack = 1'b1;
    tick(1);
    check("post_rst_fin", ostate, 2);
    iwrite_ack = 1'b0;
    iwrite_key_n = 1'b1;
    tick(1);
    check("post_rst_idle", ostate, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
